gray_step_monitor: RTL and testbench
====================================

Name: gray_step_monitor

Overview:
- Downstream consumer of the 4-bit Gray counter.
- Synchronises the free-running Gray count into the local clk domain and decodes it to binary.
- Classifies each change as an up step, a down step or an illegal jump, and keeps a saturating count of legal steps.
- Gives following logic a clean binary position, step/wrap event pulses and a fault indication.

Parameters:
- WIDTH, 4, width of Gray input and binary output.
- SYNC_STAGES, 2, number of synchroniser flops on gray_in (minimum 2).
- CNT_W, 16, width of step counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- gray_in  input  WIDTH  Gray count from upstream counter, asynchronous to clk.
- clr  input  1  synchronous clear: re-acquire, zero counter, clear fault.
- bin_out  output  WIDTH  decoded binary of last accepted sample.
- bin_valid  output  1  high once a reference sample is acquired.
- step_up  output  1  one-cycle pulse, accepted value = previous+1 mod 2^WIDTH.
- step_dn  output  1  one-cycle pulse, accepted value = previous-1 mod 2^WIDTH.
- wrap  output  1  one-cycle pulse on max->0 (up) or 0->max (down).
- err  output  1  one-cycle pulse on illegal jump.
- err_sticky  output  1  latched fault flag.
- step_cnt  output  CNT_W  count of legal steps (up plus down), saturating.

Behaviour:
- Reset: asynchronous, active-low; clk is the only clock.
  - All synchroniser flops, bin_out, step_cnt = 0.
  - bin_valid, step_up, step_dn, wrap, err, err_sticky = 0.
  - State = INIT.
- Sync and decode:
  - gray_in passes through SYNC_STAGES flops, giving g_s.
  - Combinational decode gives d: d[MSB] = g_s[MSB]; d[i] = d[i+1] ^ g_s[i].
  - delta = d - bin_out, modulo 2^WIDTH.
- Latency: a gray_in change reaches bin_out and the pulses SYNC_STAGES+1 cycles later. All outputs are registered.
- FSM:
  - INIT: wait SYNC_STAGES cycles after reset or clr for the pipeline to fill (fill counter). Then load bin_out = d, set bin_valid = 1, go to TRACK. No pulses in INIT.
  - TRACK, per cycle:
    - delta = 0: hold, no pulse.
    - delta = 1: bin_out = d, step_up = 1, step_cnt += 1.
    - delta = 2^WIDTH-1: bin_out = d, step_dn = 1, step_cnt += 1.
    - Any other delta: err = 1, err_sticky = 1, bin_out = d, go to FAULT, step_cnt unchanged.
  - FAULT: bin_out follows d every cycle. No step, wrap or err pulses. step_cnt frozen. Leave only via clr.
- wrap:
  - Asserted together with step_up when bin_out = 2^WIDTH-1 and d = 0.
  - Asserted together with step_dn when bin_out = 0 and d = 2^WIDTH-1.
- step_cnt saturates at 2^CNT_W-1; further legal steps still pulse but do not increment.
- clr:
  - Any state -> INIT, restarts fill counter.
  - Same cycle: step_cnt = 0, err_sticky = 0, bin_valid = 0, all pulses 0.
  - clr beats a simultaneous step or error.
  - bin_out holds until re-acquired.
- Reset mid-operation: asynchronous return to the reset values above, independent of state.

Optional Feature:
- Macro: GRAY_MON_FILT_EN.
- Defined:
  - A stability filter is added after the synchroniser: a new d is accepted only after two consecutive equal samples.
  - Latency becomes SYNC_STAGES+2.
  - A single-cycle glitch value is discarded without err.
  - The INIT fill wait becomes SYNC_STAGES+1.
- Undefined: no filter; every synchronised sample is evaluated. Latency SYNC_STAGES+1.

Test Plan:
- Reset then gray_in = 0000 steady, WIDTH=4: bin_valid rises at cycle 3 with bin_out = 0; no pulses; step_cnt = 0.
- Walk gray_in 0000->0001->0011->0010, one change per 4 cycles: bin_out 1, 2, 3; step_up three times; step_cnt = 3; each 3 cycles after its change.
- From 1000 (bin 15) to 0000: bin_out = 0, step_up and wrap in the same cycle. Then 0000->1000: step_dn and wrap, bin_out = 15.
- From 0000 to 0100 (bin 7): err pulse, err_sticky = 1, bin_out = 7. Further legal steps produce no pulses and step_cnt is frozen. clr: err_sticky = 0, step_cnt = 0, re-acquire after 2 cycles.
- Preset to near saturation with CNT_W=2 and 4 up steps: step_cnt stops at 3 and step_up still pulses on the 4th. clr asserted in the same cycle as a legal step: step_cnt = 0, no pulse.
- GRAY_MON_FILT_EN defined, one-cycle glitch 0000->0110->0000 in g_s: no err, no pulse, bin_out stays 0. With the macro undefined, the same stimulus gives err = 1.

Source files
------------

// File: rtl/gray_step_monitor.sv
// Gray step monitor: synchronises a free-running Gray count, decodes it to binary and
// classifies each change as up step, down step or illegal jump. Optional filter: GRAY_MON_FILT_EN.
module gray_step_monitor #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             wrap,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] step_cnt
);

`ifdef GRAY_MON_FILT_EN
  localparam int FILL_N = SYNC_STAGES + 1;
`else
  localparam int FILL_N = SYNC_STAGES;
`endif
  localparam int FW = $clog2(FILL_N + 1);

  localparam logic [WIDTH-1:0] BIN_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] BIN_MAX  = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [FW-1:0]    FILL_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0]    FILL_ONE  = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0]    FILL_END  = FW'(FILL_N);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] g_f;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] delta;

  state_t           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] bin_out_q, bin_out_d;
  logic             bin_valid_q, bin_valid_d;
  logic             step_up_q, step_up_d;
  logic             step_dn_q, step_dn_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  // Synchroniser shift chain; gray_in enters stage 0.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

`ifdef GRAY_MON_FILT_EN
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  // A sample is passed on only when it matches the one before it; otherwise the last stable value is held.
  always_comb begin
    samp_d = g_s;
    if (g_s == samp_q) begin
      g_f = g_s;
    end else begin
      g_f = hold_q;
    end
    hold_d = g_f;
  end

  // Filter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= BIN_ZERO;
      hold_q <= BIN_ZERO;
    end else begin
      samp_q <= samp_d;
      hold_q <= hold_d;
    end
  end
`else
  assign g_f = g_s;
`endif

  assign d     = gray_to_bin(g_f);
  assign delta = d - bin_out_q;

  // Next-state and output logic; clr overrides everything except bin_out.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    bin_out_d    = bin_out_q;
    bin_valid_d  = bin_valid_q;
    step_up_d    = 1'b0;
    step_dn_d    = 1'b0;
    wrap_d       = 1'b0;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    step_cnt_d   = step_cnt_q;

    if (clr) begin
      state_d      = ST_INIT;
      fill_d       = FILL_ZERO;
      bin_valid_d  = 1'b0;
      err_sticky_d = 1'b0;
      step_cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (fill_q == FILL_END) begin
            bin_out_d   = d;
            bin_valid_d = 1'b1;
            state_d     = ST_TRACK;
          end else begin
            fill_d = fill_q + FILL_ONE;
          end
        end
        ST_TRACK: begin
          if (delta == BIN_ZERO) begin
            bin_out_d = bin_out_q;
          end else if (delta == BIN_ONE || delta == BIN_MAX) begin
            bin_out_d = d;
            if (delta == BIN_ONE) begin
              step_up_d = 1'b1;
              wrap_d    = (bin_out_q == BIN_MAX);
            end else begin
              step_dn_d = 1'b1;
              wrap_d    = (bin_out_q == BIN_ZERO);
            end
            if (step_cnt_q != CNT_MAX) begin
              step_cnt_d = step_cnt_q + CNT_ONE;
            end else begin
              step_cnt_d = step_cnt_q;
            end
          end else begin
            bin_out_d    = d;
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
            state_d      = ST_FAULT;
          end
        end
        ST_FAULT: begin
          bin_out_d = d;
        end
        default: begin
          state_d     = ST_INIT;
          fill_d      = FILL_ZERO;
          bin_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '{default: BIN_ZERO};
      state_q      <= ST_INIT;
      fill_q       <= FILL_ZERO;
      bin_out_q    <= BIN_ZERO;
      bin_valid_q  <= 1'b0;
      step_up_q    <= 1'b0;
      step_dn_q    <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      step_cnt_q   <= CNT_ZERO;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      fill_q       <= fill_d;
      bin_out_q    <= bin_out_d;
      bin_valid_q  <= bin_valid_d;
      step_up_q    <= step_up_d;
      step_dn_q    <= step_dn_d;
      wrap_q       <= wrap_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign bin_out    = bin_out_q;
  assign bin_valid  = bin_valid_q;
  assign step_up    = step_up_q;
  assign step_dn    = step_dn_q;
  assign wrap       = wrap_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed bench for gray_step_monitor: a default instance and a CNT_W=2 instance share stimulus.
module tb_gray_step_monitor;

`ifdef GRAY_MON_FILT_EN
  localparam int LAT  = 4;
  localparam int FILL = 3;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam int FILL = 2;
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [3:0]  gray_in;

  logic [3:0]  bin_out, s_bin_out;
  logic        bin_valid, s_bin_valid;
  logic        step_up, s_step_up;
  logic        step_dn, s_step_dn;
  logic        wrap, s_wrap;
  logic        err, s_err;
  logic        err_sticky, s_err_sticky;
  logic [15:0] step_cnt;
  logic [1:0]  s_step_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_step_monitor #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .step_up(step_up), .step_dn(step_dn),
    .wrap(wrap), .err(err), .err_sticky(err_sticky), .step_cnt(step_cnt)
  );

  gray_step_monitor #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr),
    .bin_out(s_bin_out), .bin_valid(s_bin_valid), .step_up(s_step_up), .step_dn(s_step_dn),
    .wrap(s_wrap), .err(s_err), .err_sticky(s_err_sticky), .step_cnt(s_step_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one new Gray value, hold it 4 cycles, check the pulse cycle and the cycle after.
  task automatic apply(input logic [3:0] g, input logic [3:0] eb, input logic eu, input logic ed,
                       input logic ew, input logic ee, input logic [15:0] ecnt, input logic [1:0] escnt);
    gray_in = g;
    repeat (LAT - 1) tick();
    check("no_early_pulse", {step_up, step_dn, wrap, err}, 4'b0000);
    tick();
    check("bin_out", bin_out, eb);
    check("step_up", step_up, eu);
    check("step_dn", step_dn, ed);
    check("wrap", wrap, ew);
    check("err", err, ee);
    check("step_cnt", step_cnt, ecnt);
    check("sat_step_up", s_step_up, eu);
    check("sat_step_cnt", s_step_cnt, escnt);
    tick();
    check("pulse_width", {step_up, step_dn, wrap, err}, 4'b0000);
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    gray_in = 4'b0000;
    repeat (2) tick();
    check("rst_bin_out", bin_out, 4'd0);
    check("rst_valid", bin_valid, 1'b0);
    check("rst_cnt", step_cnt, 16'd0);
    check("rst_sticky", err_sticky, 1'b0);
    check("rst_pulses", {step_up, step_dn, wrap, err}, 4'b0000);

    rst_n = 1'b1;
    repeat (FILL) tick();
    check("init_not_valid", bin_valid, 1'b0);
    tick();
    check("init_valid", bin_valid, 1'b1);
    check("init_bin", bin_out, 4'd0);
    check("init_pulses", {step_up, step_dn, wrap, err}, 4'b0000);
    check("init_cnt", step_cnt, 16'd0);

    // Full upward walk 1..15, then wrap up, wrap down, wrap up.
    for (int i = 1; i < 16; i++) begin
      apply(gray_tab[i], 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 16'(i), (i > 3) ? 2'd3 : 2'(i));
    end
    apply(4'b0000, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 16'd16, 2'd3);
    apply(4'b1000, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 16'd17, 2'd3);
    apply(4'b0000, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 16'd18, 2'd3);

    // Illegal jump 0 -> 7, then a legal step while faulted.
    apply(4'b0100, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 16'd18, 2'd3);
    check("sticky_set", err_sticky, 1'b1);
    apply(4'b1100, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'd18, 2'd3);
    check("sticky_hold", err_sticky, 1'b1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_sticky", err_sticky, 1'b0);
    check("clr_cnt", step_cnt, 16'd0);
    check("clr_sat_cnt", s_step_cnt, 2'd0);
    check("clr_valid", bin_valid, 1'b0);
    check("clr_bin_hold", bin_out, 4'd8);
    repeat (FILL) tick();
    check("reacq_not_valid", bin_valid, 1'b0);
    tick();
    check("reacq_valid", bin_valid, 1'b1);
    check("reacq_bin", bin_out, 4'd8);

    // Saturation of the 2-bit counter: 1,2,3,3 with the 4th step still pulsing.
    for (int k = 1; k <= 4; k++) begin
      apply(gray_tab[8 + k], 4'(8 + k), 1'b1, 1'b0, 1'b0, 1'b0, 16'(k), (k > 3) ? 2'd3 : 2'(k));
    end

    // clr lands on the same edge as the step 12 -> 13.
    gray_in = gray_tab[13];
    repeat (LAT - 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_beats_step_pulse", step_up, 1'b0);
    check("clr_beats_step_cnt", step_cnt, 16'd0);
    check("clr_beats_step_sat", s_step_cnt, 2'd0);
    check("clr_beats_step_bin", bin_out, 4'd12);
    repeat (FILL + 1) tick();
    check("clr2_valid", bin_valid, 1'b1);
    check("clr2_bin", bin_out, 4'd13);

    // One-cycle glitch 13 -> 4 -> 13.
    gray_in = 4'b0110;
    tick();
    gray_in = gray_tab[13];
    repeat (2) tick();
    check("glitch_err", err, FILT ? 1'b0 : 1'b1);
    check("glitch_bin", bin_out, FILT ? 4'd13 : 4'd4);
    check("glitch_up", step_up, 1'b0);
    repeat (3) tick();
    check("glitch_after_err", err, 1'b0);
    check("glitch_after_bin", bin_out, 4'd13);
    check("glitch_sticky", err_sticky, FILT ? 1'b0 : 1'b1);

    // Asynchronous reset between clock edges.
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_bin", bin_out, 4'd0);
    check("async_rst_valid", bin_valid, 1'b0);
    check("async_rst_sticky", err_sticky, 1'b0);
    check("async_rst_cnt", step_cnt, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
